// File: rtl/hawk_decomp_manager.sv
// Decompression-path sequencer: header read, destination way handoff,
// compressed body stream into the read-data FIFO, completion pulse.
//
//   state       | meaning
//   IDLE        | waiting for decomp_trigger
//   HDR_REQ     | issue single-beat AR for the header
//   HDR_WAIT    | receive header beat, check size
//   SETUP       | flush FIFO, announce way, start decompressor
//   BODY_REQ    | issue AR burst for the compressed body
//   BODY_WAIT   | stream body beats, throttled by FIFO full
//   DECOMP_WAIT | wait for decompressor completion
//   DONE        | completion pulse
//   ERROR       | sticky bus/format error, drain R channel
module hawk_decomp_manager #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int PAGE_BYTES     = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      decomp_trigger,
  input  logic [AXI_ADDR_WIDTH-1:0] decomp_cPage_byteStart,
  input  logic [AXI_ADDR_WIDTH-1:0] decomp_freeWay,
  input  logic                      arready,
  input  logic                      rvalid,
  input  logic                      rlast,
  input  logic [1:0]                rresp,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic                      rdfifo_full,
  input  logic                      decomp_done,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  output logic                      rready,
  output logic [AXI_DATA_WIDTH-1:0] hdr_rdata,
  output logic                      decomp_rdm_reset,
  output logic                      decomp_start,
  output logic                      dc_pkt_valid,
  output logic [AXI_ADDR_WIDTH-1:0] dc_pkt_way,
  output logic                      decomp_mngr_done,
  output logic                      decomp_error,
  output logic [3:0]                state
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    HDR_REQ     = 4'd1,
    HDR_WAIT    = 4'd2,
    SETUP       = 4'd3,
    BODY_REQ    = 4'd4,
    BODY_WAIT   = 4'd5,
    DECOMP_WAIT = 4'd6,
    DONE        = 4'd7,
    ERROR       = 4'd8
  } state_e;

  localparam logic [13:0] CSIZE_MAX = 14'(PAGE_BYTES - 64);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cpage_q, cpage_d;
  logic [AXI_ADDR_WIDTH-1:0] way_q, way_d;
  logic [13:0]               csize_q, csize_d;
  logic                      done_lat_q, done_lat_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_d, pkt_way_d;
  logic [7:0]                arlen_d;
  logic                      arvalid_d, rready_d;
  logic [AXI_DATA_WIDTH-1:0] hdr_d;
  logic                      setup_d, mngr_done_d, error_d;
  logic                      r_acc;

  assign r_acc = rvalid & rready;
  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    cpage_d    = cpage_q;
    way_d      = way_q;
    csize_d    = csize_q;
    done_lat_d = done_lat_q;
    araddr_d   = araddr;
    arlen_d    = arlen;
    // an issued AR stays up until the slave takes it
    arvalid_d  = arvalid & ~arready;
    hdr_d      = hdr_rdata;
    pkt_way_d  = dc_pkt_way;

    case (state_q)
      IDLE: begin
        done_lat_d = 1'b0;
        if (decomp_trigger) begin
          cpage_d = decomp_cPage_byteStart;
          way_d   = decomp_freeWay;
          state_d = HDR_REQ;
        end
      end
      HDR_REQ: begin
        if (arready && !arvalid) begin
          araddr_d  = cpage_q;
          arlen_d   = 8'd0;
          arvalid_d = 1'b1;
          state_d   = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (r_acc && rlast) begin
          if (rresp != 2'b00) begin
            state_d = ERROR;
          end else begin
            hdr_d   = rdata;
            csize_d = rdata[13:0];
            if (rdata[13:0] == 14'd0 || rdata[13:0] > CSIZE_MAX) state_d = ERROR;
            else                                                 state_d = SETUP;
          end
        end
      end
      SETUP: state_d = BODY_REQ;
      BODY_REQ: begin
        if (arready && !arvalid) begin
          araddr_d  = cpage_q + AXI_ADDR_WIDTH'(64);
          // ceil(csize/64)-1 == floor((csize-1)/64) for csize >= 1
          arlen_d   = 8'((csize_q - 14'd1) >> 6);
          arvalid_d = 1'b1;
          state_d   = BODY_WAIT;
        end
      end
      BODY_WAIT: begin
        if (decomp_done) done_lat_d = 1'b1;
        if (r_acc) begin
          if (rresp != 2'b00) state_d = ERROR;
          else if (rlast)     state_d = DECOMP_WAIT;
        end
      end
      DECOMP_WAIT: if (decomp_done || done_lat_q) state_d = DONE;
      DONE:        state_d = IDLE;
      ERROR:       state_d = ERROR;
      default:     state_d = IDLE;
    endcase

    setup_d     = (state_d == SETUP);
    mngr_done_d = (state_d == DONE);
    error_d     = (state_d == ERROR);
    if (setup_d) pkt_way_d = way_q;
    rready_d = (state_d == HDR_WAIT) || (state_d == ERROR) ||
               ((state_d == BODY_WAIT) && !rdfifo_full);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      cpage_q          <= '0;
      way_q            <= '0;
      csize_q          <= '0;
      done_lat_q       <= 1'b0;
      araddr           <= '0;
      arlen            <= '0;
      arvalid          <= 1'b0;
      rready           <= 1'b0;
      hdr_rdata        <= '0;
      decomp_rdm_reset <= 1'b0;
      decomp_start     <= 1'b0;
      dc_pkt_valid     <= 1'b0;
      dc_pkt_way       <= '0;
      decomp_mngr_done <= 1'b0;
      decomp_error     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cpage_q          <= cpage_d;
      way_q            <= way_d;
      csize_q          <= csize_d;
      done_lat_q       <= done_lat_d;
      araddr           <= araddr_d;
      arlen            <= arlen_d;
      arvalid          <= arvalid_d;
      rready           <= rready_d;
      hdr_rdata        <= hdr_d;
      decomp_rdm_reset <= setup_d;
      decomp_start     <= setup_d;
      dc_pkt_valid     <= setup_d;
      dc_pkt_way       <= pkt_way_d;
      decomp_mngr_done <= mngr_done_d;
      decomp_error     <= error_d;
    end
  end

endmodule

// File: tb/tb_hawk_decomp_manager.sv
// Directed bench for hawk_decomp_manager: header/body sequencing, FIFO
// back-pressure, error paths, early completion and back-to-back restart.
module tb_hawk_decomp_manager;
  localparam int AW = 64;
  localparam int DW = 512;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          decomp_trigger;
  logic [AW-1:0] decomp_cPage_byteStart, decomp_freeWay;
  logic          arready, rvalid, rlast, rdfifo_full, decomp_done;
  logic [1:0]    rresp;
  logic [DW-1:0] rdata;
  logic [AW-1:0] araddr, dc_pkt_way;
  logic [7:0]    arlen;
  logic          arvalid, rready, decomp_rdm_reset, decomp_start, dc_pkt_valid;
  logic          decomp_mngr_done, decomp_error;
  logic [DW-1:0] hdr_rdata;
  logic [3:0]    state;

  int n_pass = 0;
  int n_total = 0;

  hawk_decomp_manager #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .PAGE_BYTES(4096)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .decomp_trigger(decomp_trigger),
    .decomp_cPage_byteStart(decomp_cPage_byteStart), .decomp_freeWay(decomp_freeWay),
    .arready(arready), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rdata(rdata),
    .rdfifo_full(rdfifo_full), .decomp_done(decomp_done), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .rready(rready), .hdr_rdata(hdr_rdata),
    .decomp_rdm_reset(decomp_rdm_reset), .decomp_start(decomp_start),
    .dc_pkt_valid(dc_pkt_valid), .dc_pkt_way(dc_pkt_way),
    .decomp_mngr_done(decomp_mngr_done), .decomp_error(decomp_error), .state(state)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    decomp_trigger = 1'b0;
    arready        = 1'b1;
    rvalid         = 1'b0;
    rlast          = 1'b0;
    rresp          = 2'b00;
    rdata          = '0;
    rdfifo_full    = 1'b0;
    decomp_done    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [13:0] csize);
    logic [DW-1:0] h;
    h = '0;
    h[13:0] = csize;
    h[DW-1 -: 64] = 64'hDEAD_BEEF_CAFE_F00D;
    return h;
  endfunction

  // Starts an operation and delivers one header beat; leaves the DUT
  // just after the edge that consumed the header.
  task automatic go_header(input logic [AW-1:0] cp, input logic [AW-1:0] wy,
                           input logic [DW-1:0] hdr, input logic [1:0] resp);
    decomp_cPage_byteStart = cp;
    decomp_freeWay         = wy;
    decomp_trigger         = 1'b1;
    tick();
    decomp_trigger = 1'b0;
    tick();
    rvalid = 1'b1; rlast = 1'b1; rresp = resp; rdata = hdr;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  // Streams body beats; full_pat bit c is the FIFO-full level driven in cycle c.
  task automatic run_body(input int nbeats, input logic [31:0] full_pat,
                          output int accepted, output int bad, output int cycles);
    logic full_prev, r_now;
    full_prev = rdfifo_full;
    accepted = 0; bad = 0; cycles = 0;
    for (int c = 0; c < 64 && accepted < nbeats; c++) begin
      r_now = rready;
      if (r_now !== ~full_prev || state !== 4'd5) bad++;
      rvalid      = 1'b1;
      rlast       = (accepted == nbeats - 1);
      rdfifo_full = full_pat[c % 32];
      tick();
      full_prev = rdfifo_full;
      if (r_now) accepted++;
      cycles++;
    end
    rvalid = 1'b0; rlast = 1'b0; rdfifo_full = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    idle_inputs();
    decomp_cPage_byteStart = '0;
    decomp_freeWay = '0;
    rst_ni = 1'b0;
    #3;
    n_total++;
    if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_total++;
    if ({arvalid, rready, decomp_rdm_reset, decomp_start, dc_pkt_valid, decomp_mngr_done, decomp_error} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0", {arvalid, rready, decomp_rdm_reset, decomp_start, dc_pkt_valid, decomp_mngr_done, decomp_error});
    else n_pass++;
    n_total++;
    if (araddr !== '0 || arlen !== 8'd0 || dc_pkt_way !== '0 || hdr_rdata !== '0)
      $display("FAIL reset_data: araddr %h arlen %0d way %h want all 0", araddr, arlen, dc_pkt_way);
    else n_pass++;
    tick(); tick();
    rst_ni = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (state !== 4'd0 || arvalid !== 1'b0 || rready !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_hold: %0d bad cycles, want 0", bad); else n_pass++;
  endtask

  task automatic test_nominal();
    logic [DW-1:0] hdr;
    int acc, bad, cyc;
    do_reset();
    hdr = mk_hdr(14'd200);
    decomp_cPage_byteStart = 64'h8000_1000;
    decomp_freeWay         = 64'h8010_0000;
    decomp_trigger         = 1'b1;
    tick();
    decomp_trigger = 1'b0;
    n_total++;
    if (state !== 4'd1 || arvalid !== 1'b0) $display("FAIL nom_hdr_req: state %0d arvalid %b want 1/0", state, arvalid); else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd2 || arvalid !== 1'b1 || araddr !== 64'h8000_1000 || arlen !== 8'd0 || rready !== 1'b1)
      $display("FAIL nom_hdr_ar: state %0d arvalid %b araddr %h arlen %0d rready %b want 2/1/80001000/0/1", state, arvalid, araddr, arlen, rready);
    else n_pass++;
    rvalid = 1'b1; rlast = 1'b1; rdata = hdr;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    n_total++;
    if (state !== 4'd3 || {decomp_rdm_reset, decomp_start, dc_pkt_valid} !== 3'b111 || arvalid !== 1'b0 || rready !== 1'b0)
      $display("FAIL nom_setup: state %0d pulses %b arvalid %b rready %b want 3/111/0/0", state, {decomp_rdm_reset, decomp_start, dc_pkt_valid}, arvalid, rready);
    else n_pass++;
    n_total++;
    if (dc_pkt_way !== 64'h8010_0000 || hdr_rdata !== hdr)
      $display("FAIL nom_way_hdr: way %h want 80100000, hdr low %h want %h", dc_pkt_way, hdr_rdata[15:0], hdr[15:0]);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd4 || {decomp_rdm_reset, decomp_start, dc_pkt_valid} !== 3'b000)
      $display("FAIL nom_body_req: state %0d pulses %b want 4/000", state, {decomp_rdm_reset, decomp_start, dc_pkt_valid});
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd5 || arvalid !== 1'b1 || araddr !== 64'h8000_1040 || arlen !== 8'd3 || rready !== 1'b1)
      $display("FAIL nom_body_ar: state %0d arvalid %b araddr %h arlen %0d rready %b want 5/1/80001040/3/1", state, arvalid, araddr, arlen, rready);
    else n_pass++;
    run_body(4, 32'h0, acc, bad, cyc);
    n_total++;
    if (acc != 4 || bad != 0 || cyc != 4 || state !== 4'd6)
      $display("FAIL nom_body: beats %0d bad %0d cycles %0d state %0d want 4/0/4/6", acc, bad, cyc, state);
    else n_pass++;
    n_total++;
    if (decomp_mngr_done !== 1'b0) $display("FAIL nom_no_early_done: got %b want 0", decomp_mngr_done); else n_pass++;
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    n_total++;
    if (state !== 4'd7 || decomp_mngr_done !== 1'b1) $display("FAIL nom_done: state %0d done %b want 7/1", state, decomp_mngr_done); else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd0 || decomp_mngr_done !== 1'b0 || decomp_error !== 1'b0)
      $display("FAIL nom_idle: state %0d done %b err %b want 0/0/0", state, decomp_mngr_done, decomp_error);
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    int acc, bad, cyc;
    do_reset();
    go_header(64'h8000_1000, 64'h8010_0000, mk_hdr(14'd200), 2'b00);
    rdfifo_full = 1'b1;
    tick();
    tick();
    n_total++;
    if (state !== 4'd5 || rready !== 1'b0) $display("FAIL full_entry: state %0d rready %b want 5/0", state, rready); else n_pass++;
    // full per cycle: 0,1,1,0,1,0 then 0 -> accepts in cycles 1,4,6,7
    run_body(4, 32'h16, acc, bad, cyc);
    n_total++;
    if (acc != 4 || bad != 0 || cyc != 8 || state !== 4'd6)
      $display("FAIL full_body: beats %0d bad %0d cycles %0d state %0d want 4/0/8/6", acc, bad, cyc, state);
    else n_pass++;
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    n_total++;
    if (decomp_mngr_done !== 1'b1) $display("FAIL full_done: got %b want 1", decomp_mngr_done); else n_pass++;
  endtask

  task automatic test_hdr_error();
    int bad;
    do_reset();
    go_header(64'h8000_1000, 64'h8010_0000, mk_hdr(14'd200), 2'b10);
    n_total++;
    if (state !== 4'd8 || decomp_error !== 1'b1 || rready !== 1'b1)
      $display("FAIL hdr_err_entry: state %0d err %b rready %b want 8/1/1", state, decomp_error, rready);
    else n_pass++;
    bad = 0;
    decomp_trigger = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rvalid = i[0];
      tick();
      if (arvalid !== 1'b0 || state !== 4'd8 || decomp_error !== 1'b1 || dc_pkt_valid !== 1'b0) bad++;
    end
    rvalid = 1'b0;
    decomp_trigger = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL hdr_err_sticky: %0d bad cycles want 0", bad); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++;
    if (state !== 4'd0 || decomp_error !== 1'b0) $display("FAIL hdr_err_reset: state %0d err %b want 0/0", state, decomp_error); else n_pass++;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_csize_bounds();
    int sizes[3] = '{0, 4050, 4033};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      go_header(64'h8000_2000, 64'h8010_0000, mk_hdr(14'(sizes[i])), 2'b00);
      n_total++;
      if (state !== 4'd8 || decomp_error !== 1'b1)
        $display("FAIL csize_err_%0d: state %0d err %b want 8/1", sizes[i], state, decomp_error);
      else n_pass++;
    end
    do_reset();
    go_header(64'h8000_2000, 64'h8010_0000, mk_hdr(14'd4032), 2'b00);
    n_total++;
    if (state !== 4'd3 || decomp_error !== 1'b0) $display("FAIL csize_max_ok: state %0d err %b want 3/0", state, decomp_error); else n_pass++;
    tick();
    tick();
    n_total++;
    if (state !== 4'd5 || arlen !== 8'd62 || araddr !== 64'h8000_2040)
      $display("FAIL csize_max_ar: state %0d arlen %0d araddr %h want 5/62/80002040", state, arlen, araddr);
    else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++;
    if (state !== 4'd0 || arvalid !== 1'b0 || rready !== 1'b0)
      $display("FAIL midop_reset: state %0d arvalid %b rready %b want 0/0/0", state, arvalid, rready);
    else n_pass++;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_early_done();
    int acc, bad, cyc;
    do_reset();
    go_header(64'h1234_0000, 64'h5000, mk_hdr(14'd100), 2'b00);
    tick();
    tick();
    n_total++;
    if (state !== 4'd5 || arlen !== 8'd1) $display("FAIL early_ar: state %0d arlen %0d want 5/1", state, arlen); else n_pass++;
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    n_total++;
    if (state !== 4'd5) $display("FAIL early_stay: state %0d want 5", state); else n_pass++;
    run_body(2, 32'h0, acc, bad, cyc);
    n_total++;
    if (acc != 2 || bad != 0 || state !== 4'd6 || decomp_mngr_done !== 1'b0)
      $display("FAIL early_body: beats %0d bad %0d state %0d done %b want 2/0/6/0", acc, bad, state, decomp_mngr_done);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd7 || decomp_mngr_done !== 1'b1) $display("FAIL early_done: state %0d done %b want 7/1", state, decomp_mngr_done); else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd0 || decomp_mngr_done !== 1'b0) $display("FAIL early_idle: state %0d done %b want 0/0", state, decomp_mngr_done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, bad, cyc;
    do_reset();
    decomp_cPage_byteStart = 64'hFFFF_FFFF_FFFF_FFC0;
    decomp_freeWay         = 64'h0000_0040_0000_0000;
    decomp_trigger         = 1'b1;
    tick();
    arready = 1'b0;
    tick();
    n_total++;
    if (state !== 4'd1 || arvalid !== 1'b0) $display("FAIL b2b_ar_stall: state %0d arvalid %b want 1/0", state, arvalid); else n_pass++;
    arready = 1'b1;
    tick();
    n_total++;
    if (state !== 4'd2 || arvalid !== 1'b1 || araddr !== 64'hFFFF_FFFF_FFFF_FFC0)
      $display("FAIL b2b_hdr_ar: state %0d arvalid %b araddr %h want 2/1/ffffffffffffffc0", state, arvalid, araddr);
    else n_pass++;
    rvalid = 1'b1; rlast = 1'b1; rdata = mk_hdr(14'd64);
    tick();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    n_total++;
    if (dc_pkt_valid !== 1'b1 || dc_pkt_way !== 64'h0000_0040_0000_0000)
      $display("FAIL b2b_way: valid %b way %h want 1/0000004000000000", dc_pkt_valid, dc_pkt_way);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (state !== 4'd5 || araddr !== 64'h0 || arlen !== 8'd0)
      $display("FAIL b2b_wrap: state %0d araddr %h arlen %0d want 5/0/0", state, araddr, arlen);
    else n_pass++;
    run_body(1, 32'h0, acc, bad, cyc);
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    n_total++;
    if (acc != 1 || bad != 0 || state !== 4'd7 || decomp_mngr_done !== 1'b1)
      $display("FAIL b2b_done: beats %0d bad %0d state %0d done %b want 1/0/7/1", acc, bad, state, decomp_mngr_done);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (state !== 4'd1 || decomp_mngr_done !== 1'b0) $display("FAIL b2b_restart: state %0d done %b want 1/0", state, decomp_mngr_done); else n_pass++;
    decomp_trigger = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fifo_full();
    test_hdr_error();
    test_csize_bounds();
    test_early_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hawk_decomp_manager.md
Name: hawk_decomp_manager

Overview:
Sequencer for the decompression path of the page-read manager. When the parent holds its DECOMPRESS state, this block:
- reads the header of a compressed page over the AXI read channel,
- tells the page-write manager which uncompressed way receives the output,
- streams the compressed body into the read-data FIFO feeding the decompressor,
- pulses done when the decompressor finishes.

The parent muxes this block's AXI request, rready, rdata and rdm_reset onto the shared read port while triggered.

Parameters:
AXI_ADDR_WIDTH, 64, AXI byte-address width
AXI_DATA_WIDTH, 512, AXI read data width (one beat = 64 bytes)
PAGE_BYTES, 4096, uncompressed page size

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
decomp_trigger  in  1  level; high while parent is in DECOMPRESS
decomp_cPage_byteStart  in  AXI_ADDR_WIDTH  byte address of compressed page (header beat)
decomp_freeWay  in  AXI_ADDR_WIDTH  byte address of destination uncompressed way
arready  in  1  AXI AR ready
rvalid  in  1  AXI R valid
rlast  in  1  AXI R last
rresp  in  2  AXI R response
rdata  in  AXI_DATA_WIDTH  AXI R data
rdfifo_full  in  1  read-data FIFO full
decomp_done  in  1  decompressor finished (pulse)
araddr  out  AXI_ADDR_WIDTH  AR address
arlen  out  8  AR burst length minus one
arvalid  out  1  AR valid
rready  out  1  R ready
hdr_rdata  out  AXI_DATA_WIDTH  last captured header beat
decomp_rdm_reset  out  1  one-cycle flush of read-data FIFO
decomp_start  out  1  one-cycle start to decompressor
dc_pkt_valid  out  1  one-cycle strobe: destination way valid
dc_pkt_way  out  AXI_ADDR_WIDTH  destination way byte address
decomp_mngr_done  out  1  one-cycle completion pulse
decomp_error  out  1  sticky bus/format error
state  out  4  debug FSM state

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- All outputs are registered.
- Reset values: all outputs 0; state=IDLE.
- Reset mid-operation returns the FSM to IDLE immediately. Any outstanding AXI beats are the parent's concern.
- decomp_trigger is sampled only in IDLE. Once an operation has started, deasserting the trigger does not abort it.
- States and encodings:
  - IDLE=0
  - HDR_REQ=1
  - HDR_WAIT=2
  - SETUP=3
  - BODY_REQ=4
  - BODY_WAIT=5
  - DECOMP_WAIT=6
  - DONE=7
  - ERROR=8
- IDLE: if decomp_trigger, latch cPage_byteStart and freeWay, then go to HDR_REQ.
- HDR_REQ: when arready && !arvalid, drive araddr=cPage start, arlen=0, arvalid=1 for exactly one cycle, then go to HDR_WAIT. arvalid is held only while arready is low.
- HDR_WAIT:
  - rready=1.
  - On rvalid&&rlast: if rresp!=0, go to ERROR; else capture hdr_rdata and csize=rdata[13:0] (compressed body bytes, header excluded), then go to SETUP.
  - If csize==0 or csize>PAGE_BYTES-64, go to ERROR.
- SETUP: one cycle. Pulse decomp_rdm_reset, dc_pkt_valid (dc_pkt_way=latched freeWay) and decomp_start together, then go to BODY_REQ.
- BODY_REQ: when arready, issue araddr=cPage start+64 and arlen=ceil(csize/64)-1 (8-bit), then go to BODY_WAIT.
- BODY_WAIT:
  - rready = !rdfifo_full (registered from current-cycle full).
  - A beat is accepted only on rvalid&&rready.
  - rresp!=0 on any beat: go to ERROR.
  - Accepted rlast beat: go to DECOMP_WAIT.
- decomp_done arriving in BODY_WAIT is latched and honoured on entry to DECOMP_WAIT.
- DECOMP_WAIT: on decomp_done (or latched done), go to DONE.
- DONE: pulse decomp_mngr_done for one cycle, go to IDLE. A trigger still high in the following IDLE cycle starts a new operation (parent leaves DECOMPRESS on done).
- ERROR: decomp_error=1; rready=1 to drain; no further AR requests; stays until reset.
- rready=0 in IDLE, HDR_REQ, SETUP, BODY_REQ, DECOMP_WAIT, DONE.
- Address arithmetic is unsigned, modulo 2^AXI_ADDR_WIDTH.

Test Plan:
- Reset, trigger=0 -> all outputs 0, state=0 indefinitely.
- Trigger with cPage=0x8000_1000, freeWay=0x8010_0000, header csize=200 -> header AR at 0x80001000 arlen=0; one-cycle SETUP pulses with dc_pkt_way=0x80100000; body AR at 0x80001040 arlen=3; after 4 beats and decomp_done, decomp_mngr_done pulses once.
- Body read with rdfifo_full toggling -> rready tracks !full; no beat accepted while full; completes after all 4 beats.
- Header rresp=2 -> ERROR, decomp_error=1, no body AR issued, sticky until reset.
- Header csize=0 and csize=4050 -> ERROR in both cases.
- decomp_done asserted during BODY_WAIT, before rlast -> done latched; decomp_mngr_done pulses one cycle after DECOMP_WAIT is entered.
